// File: rtl/acq_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module : acq_frame_scheduler
// Desc   : Frame-aligned acquisition sequencer between the 8-to-64 ADC packer
//          and the 64-bit host FIFO. Forwards a requested number of whole
//          frames and drops any frame the FIFO cannot hold in its entirety.
// Rev    : 1.0  initial release
// ============================================================================
module acq_frame_scheduler #(
  parameter int DW      = 64,
  parameter int FIFO_AW = 12,
  parameter int CNT_W   = 16,
  parameter int TAG_LSB = 48,
  parameter int TAG_W   = 13
) (
  input  logic               InputClock,
  input  logic               rst,
  input  logic               cmd_start,
  input  logic               cmd_abort,
  input  logic [CNT_W-1:0]   frames_req,
  input  logic [12:0]        frame_len,
  input  logic [DW-1:0]      word_in,
  input  logic               word_strobe,
  input  logic [FIFO_AW:0]   fifo_free,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_din,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   frames_done,
  output logic [CNT_W-1:0]   frames_dropped,
  output logic               err_overflow,
  output logic               err_sync
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_SKIP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   req_q, req_d;
  logic [12:0]        len_q, len_d;
  logic [13:0]        wc_q, wc_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               ovf_q, ovf_d;
  logic               sync_q, sync_d;
  logic               wr_q, wr_d;
  logic [DW-1:0]      din_q, din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [13:0]        frame_words;
  logic [13:0]        wc_inc;
  logic               is_start;
  logic               has_room;
  logic               last_frame;
  logic               eval_start;

  // Counters stop at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign frame_words = {1'b0, len_q} + 14'd1;
  assign wc_inc      = wc_q + 14'd1;
  assign is_start    = word_strobe && (word_in[TAG_LSB +: TAG_W] == '0);
  assign has_room    = 32'(fifo_free) >= 32'(frame_words);
  // Compared one bit wider so a saturated counter never matches by wrap-around.
  assign last_frame  = ((CNT_W+1)'(done_cnt_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(req_q);

  // Next-state, counter and write-port logic; abort is applied last so it overrides.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    len_d      = len_q;
    wc_d       = wc_q;
    done_cnt_d = done_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    sync_d     = sync_q;
    wr_d       = 1'b0;
    din_d      = din_q;
    done_d     = 1'b0;
    eval_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          req_d      = frames_req;
          len_d      = frame_len;
          done_cnt_d = '0;
          drop_cnt_d = '0;
          ovf_d      = 1'b0;
          sync_d     = 1'b0;
          state_d    = (frames_req == '0) ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        if (is_start) eval_start = 1'b1;
      end
      S_CAPTURE: begin
        if (is_start) begin
          // A new frame began before this one ended: flag it and restart on it.
          sync_d     = 1'b1;
          eval_start = 1'b1;
        end else if (word_strobe) begin
          if (fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_d  = 1'b1;
            din_d = word_in;
          end
          wc_d = wc_inc;
          if (wc_inc == frame_words) begin
            done_cnt_d = sat_inc(done_cnt_q);
            state_d    = last_frame ? S_DONE : S_ARM;
          end
        end
      end
      S_SKIP: begin
        if (is_start) begin
          sync_d     = 1'b1;
          eval_start = 1'b1;
        end else if (word_strobe) begin
          wc_d = wc_inc;
          if (wc_inc == frame_words) state_d = S_ARM;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Admission decision for a frame-start word; a one-word frame also ends here.
    if (eval_start) begin
      wc_d = 14'd1;
      if (has_room) begin
        if (fifo_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_d  = 1'b1;
          din_d = word_in;
        end
        if (frame_words == 14'd1) begin
          done_cnt_d = sat_inc(done_cnt_q);
          state_d    = last_frame ? S_DONE : S_ARM;
        end else begin
          state_d = S_CAPTURE;
        end
      end else begin
        drop_cnt_d = sat_inc(drop_cnt_q);
        state_d    = (frame_words == 14'd1) ? S_ARM : S_SKIP;
      end
    end

    if (cmd_abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      wc_d       = wc_q;
      done_cnt_d = done_cnt_q;
      drop_cnt_d = drop_cnt_q;
      ovf_d      = ovf_q;
      sync_d     = sync_q;
      wr_d       = 1'b0;
      din_d      = din_q;
      done_d     = 1'b0;
    end

    busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE) || (state_d == S_SKIP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge InputClock) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      len_q      <= '0;
      wc_q       <= '0;
      done_cnt_q <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      sync_q     <= 1'b0;
      wr_q       <= 1'b0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      len_q      <= len_d;
      wc_q       <= wc_d;
      done_cnt_q <= done_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      sync_q     <= sync_d;
      wr_q       <= wr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fifo_wr_en     = wr_q;
  assign fifo_din       = din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign frames_done    = done_cnt_q;
  assign frames_dropped = drop_cnt_q;
  assign err_overflow   = ovf_q;
  assign err_sync       = sync_q;

endmodule
`default_nettype wire
